// File: rtl/stepper_pkg.sv
// stepper_pkg: shared FSM encoding and coil pattern tables.
// Half-step table used when STEPPER_HALFSTEP_EN is defined.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] FULL_P0 = 4'b0011;
    localparam logic [3:0] FULL_P1 = 4'b0110;
    localparam logic [3:0] FULL_P2 = 4'b1100;
    localparam logic [3:0] FULL_P3 = 4'b1001;

    localparam logic [3:0] HALF_P0 = 4'b0001;
    localparam logic [3:0] HALF_P1 = 4'b0011;
    localparam logic [3:0] HALF_P2 = 4'b0010;
    localparam logic [3:0] HALF_P3 = 4'b0110;
    localparam logic [3:0] HALF_P4 = 4'b0100;
    localparam logic [3:0] HALF_P5 = 4'b1100;
    localparam logic [3:0] HALF_P6 = 4'b1000;
    localparam logic [3:0] HALF_P7 = 4'b1001;

    function automatic logic [3:0] full_pat(input logic [1:0] i);
        logic [3:0] p;
        unique case (i)
            2'd0: p = FULL_P0;
            2'd1: p = FULL_P1;
            2'd2: p = FULL_P2;
            default: p = FULL_P3;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] half_pat(input logic [2:0] i);
        logic [3:0] p;
        unique case (i)
            3'd0: p = HALF_P0;
            3'd1: p = HALF_P1;
            3'd2: p = HALF_P2;
            3'd3: p = HALF_P3;
            3'd4: p = HALF_P4;
            3'd5: p = HALF_P5;
            3'd6: p = HALF_P6;
            default: p = HALF_P7;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/stepper_phase_seq.sv
// stepper_phase_seq: phase index register and pattern lookup.
// STEPPER_HALFSTEP_EN selects the 8-entry half-step table.
module stepper_phase_seq
    import stepper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    output logic [3:0] pattern
);

`ifdef STEPPER_HALFSTEP_EN
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;
    localparam logic [IDX_W-1:0] IDX_RST  = 3'd1;
`else
    localparam int IDX_W = 2;
    localparam logic [IDX_W-1:0] IDX_LAST = 2'd3;
    localparam logic [IDX_W-1:0] IDX_RST  = 2'd0;
`endif

    logic [IDX_W-1:0] idx_q, idx_d;

    // Walk one entry per step, wrapping at either end.
    always_comb begin
        idx_d = idx_q;
        if (step) begin
            if (dir)
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            else
                idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
        end
    end

    // Index survives between moves; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            idx_q <= IDX_RST;
        else
            idx_q <= idx_d;
    end

`ifdef STEPPER_HALFSTEP_EN
    assign pattern = half_pat(idx_q);
`else
    assign pattern = full_pat(idx_q);
`endif

endmodule

// File: rtl/stepper_ctrl.sv
// stepper_ctrl: timed step-move controller with abort and hold.
// STEPPER_HALFSTEP_EN enables half-step sequencing.
module stepper_ctrl
    import stepper_pkg::*;
#(
    parameter int CNT_W = 12,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             hold,
    output logic [3:0]       phase,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pos
);

    localparam logic [DIV_W-1:0] T_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [15:0]      pos_q, pos_d;
    logic             busy_q, done_q, rdy_q;
    logic             step;
    logic [3:0]       pattern;

    // Next-state: accept, count down, issue steps, finish.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        per_d   = per_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && rdy_q) begin
                    if (cmd_steps == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        dir_d   = cmd_dir;
                        rem_d   = cmd_steps;
                        per_d   = (cmd_period == '0) ? T_ONE
                                                     : cmd_period;
                        timer_d = per_d;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_FIN;
                end else if (timer_q == T_ONE) begin
                    step    = 1'b1;
                    timer_d = per_q;
                    rem_d   = rem_q - C_ONE;
                    pos_d   = dir_q ? pos_q + 16'd1
                                    : pos_q - 16'd1;
                    if (rem_q == C_ONE)
                        state_d = ST_FIN;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            per_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            per_q   <= per_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_FIN);
            rdy_q   <= (state_d == ST_IDLE);
        end
    end

    stepper_phase_seq u_seq (
        .clk     (clk),
        .rst     (rst),
        .step    (step),
        .dir     (dir_q),
        .pattern (pattern)
    );

    assign phase     = (busy_q || hold) ? pattern : 4'b0000;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = rdy_q;
    assign pos       = pos_q;

endmodule

// File: doc/stepper_ctrl.md
STEPPER_CTRL -- requirements
Module: stepper_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of step-count command.
REQ-002 SHALL have parameter DIV_W, default 16, width of step-period command, in clk cycles.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  move command offered.
REQ-006 SHALL have port cmd_ready  output  1  controller accepts a command.
REQ-007 SHALL have port cmd_dir  input  1  1 = forward, 0 = reverse.
REQ-008 SHALL have port cmd_steps  input  CNT_W  number of steps to issue.
REQ-009 SHALL have port cmd_period  input  DIV_W  clk cycles between steps.
REQ-010 SHALL have port abort  input  1  terminate current move.
REQ-011 SHALL have port hold  input  1  keep coils energised while idle.
REQ-012 SHALL have port phase  output  4  coil drive pattern.
REQ-013 SHALL have port busy  output  1  move in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at move end.
REQ-015 SHALL have port pos  output  16  signed step position.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and FIN.
REQ-017 SHALL assert cmd_ready only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-018 SHALL, on acceptance with cmd_steps=0, go to FIN with no step; otherwise latch dir and steps, load the timer with max(cmd_period,1), and go to RUN.
REQ-019 SHALL, in RUN, decrement the timer each cycle; on the cycle the timer reaches 1, advance the phase index one position in the latched direction, decrement remaining steps and reload the timer.
REQ-020 SHALL make the interval between steps exactly max(period,1) cycles; the first step occurs max(period,1) cycles after acceptance.
REQ-021 SHALL go to FIN on the cycle the last step is issued.
REQ-022 SHALL hold FIN for one cycle with done=1, then return to IDLE; busy=1 in RUN and FIN only.
REQ-023 SHALL, when abort=1 in RUN, go to FIN with no further step; abort coincident with timer expiry SHALL suppress that step; abort SHALL be ignored in IDLE and FIN.
REQ-024 SHALL use the full-step sequence 0011, 0110, 1100, 1001 (forward order), wrapping 1001 to 0011; reverse walks the sequence backwards, wrapping 0011 to 1001.
REQ-025 SHALL retain the phase index between moves.
REQ-026 SHALL drive phase with the sequence pattern when busy or hold is 1, else 4'b0000.
REQ-027 SHALL increment pos on each forward step and decrement it on each reverse step, wrapping in two's complement (32767+1 = -32768).
REQ-028 SHALL ignore cmd_steps, cmd_dir and cmd_period changes after acceptance.

Reset
REQ-029 SHALL, on rst=0, immediately force state IDLE, phase index to pattern 0011, pos=0, timer=0, remaining=0, done=0, busy=0 and cmd_ready=0 while rst is low.
REQ-030 SHALL, when reset is asserted mid-move, discard the move without a done pulse.

Configuration
REQ-031 SHALL, with STEPPER_HALFSTEP_EN defined, use the 8-entry half-step sequence 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001 and reset to 0011; each step advances one entry and changes pos by 1.
REQ-032 SHALL, without STEPPER_HALFSTEP_EN, use only the 4-entry full-step sequence of REQ-024.

Structure
REQ-033 SHALL place the FSM state encoding and the phase pattern constants for both sequences in package stepper_pkg.
REQ-034 SHALL isolate the phase index register and its pattern lookup in sub-module stepper_phase_seq, with inputs step and dir and output pattern.

Verification
REQ-035 SHALL cover: reset, then steps=4, dir=1, period=3 -> phase 0110, 1100, 1001, 0011 at cycles 3, 6, 9, 12 after accept; done pulse; pos=4.
REQ-036 SHALL cover: steps=2, dir=0, period=0 from phase 0011 -> steps on consecutive cycles, phase 1001 then 1100, pos=-2.
REQ-037 SHALL cover: steps=0 -> no phase change, done pulse 1 cycle after accept, pos unchanged.
REQ-038 SHALL cover: steps=10, period=5, abort asserted on the 3rd step's expiry cycle -> exactly 2 steps, done pulse, cmd_ready high afterwards.
REQ-039 SHALL cover: hold=0 after move -> phase=0000; hold=1 -> last pattern restored; cmd_valid during RUN -> not accepted.
REQ-040 SHALL cover: pos preset by 32767 forward steps, one more forward step -> pos=-32768; rst pulse mid-move -> phase 0011, pos 0, no done.
